// File: rtl/exu_ldst_queue.sv
// exu_ldst_queue: execute-stage load/store unit with an in-order tag FIFO.
// Computes the effective address and issues lane-aligned, byte-strobed memory
// requests. Up to MAX_OUTST accesses may be outstanding. Responses become GPR
// write-backs or access-fault exceptions. Illegal or misaligned operations are
// consumed without a request and reported as registered exceptions.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both 1. Valid never depends on ready of the same channel. issue_rdy may
// depend on req_rdy, because a good operation moves issue->req combinationally.
module exu_ldst_queue #(
  parameter int XLEN      = 32,
  parameter int GPR_AW    = 5,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst,
  // operation from the EXU
  input  logic              issue_vld,
  output logic              issue_rdy,
  input  logic              issue_st,
  input  logic [2:0]        issue_funct3,
  input  logic [GPR_AW-1:0] issue_rd,
  input  logic [XLEN-1:0]   issue_base,
  input  logic [XLEN-1:0]   issue_offset,
  input  logic [XLEN-1:0]   issue_wdata,
  // data-memory request channel
  output logic              req_vld,
  input  logic              req_rdy,
  output logic [XLEN-1:0]   req_addr,
  output logic              req_st,
  output logic [XLEN-1:0]   req_data,
  output logic [XLEN/8-1:0] req_strobe,
  // data-memory response channel
  input  logic              rsp_vld,
  output logic              rsp_rdy,
  input  logic [XLEN-1:0]   rsp_data,
  input  logic              rsp_err,
  // GPR write port
  output logic              wb_en,
  output logic [GPR_AW-1:0] wb_addr,
  output logic [XLEN-1:0]   wb_data,
  // exception report
  output logic              excp_vld,
  output logic [1:0]        excp_cause,
  output logic [XLEN-1:0]   excp_addr,
  // status
  output logic              busy,
  output logic              proto_err
);

  localparam int  SW   = XLEN / 8;
  localparam int  OW   = $clog2(SW);
  localparam int  PW   = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int  CW   = $clog2(MAX_OUTST + 1);
  localparam int  EW   = 1 + 3 + GPR_AW + OW + XLEN;
  localparam bit  IS64 = (XLEN == 64);

  // issue-side decode
  logic [XLEN-1:0] ea;
  logic [OW-1:0]   off;
  logic [31:0]     nbytes;
  logic            legal;
  logic            misalign;
  logic            bad;
  logic [1:0]      bad_cause;
  logic [SW-1:0]   strb_base;

  // FIFO state
  logic [EW-1:0]   fifo_mem [MAX_OUTST];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            bad_hs;
  logic            fault;

  // FIFO head fields
  logic [EW-1:0]     head;
  logic [XLEN-1:0]   h_ea;
  logic [OW-1:0]     h_off;
  logic [GPR_AW-1:0] h_rd;
  logic [2:0]        h_f3;
  logic              h_st;

  // load data alignment / extension
  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] ext_mask;
  logic [XLEN-1:0] top_bit;
  logic            sgn;

  // pending issue-side exception (deferred behind a response fault)
  logic            pend_vld;
  logic [1:0]      pend_cause;
  logic [XLEN-1:0] pend_addr;

  // Decode the incoming operation: address, legality, alignment, byte mask.
  always_comb begin
    ea     = issue_base + issue_offset;
    off    = ea[OW-1:0];
    nbytes = 32'd1 << issue_funct3[1:0];
    legal  = 1'b0;
    if (issue_st) begin
      legal = (issue_funct3 <= 3'd2) || (IS64 && (issue_funct3 == 3'd3));
    end else begin
      case (issue_funct3)
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: legal = 1'b1;
        3'd3, 3'd6:                   legal = IS64;
        default:                      legal = 1'b0;
      endcase
    end
    misalign  = (off & OW'(nbytes - 32'd1)) != '0;
    bad       = ~legal | misalign;
    bad_cause = ~legal ? 2'd3 : (issue_st ? 2'd1 : 2'd0);
    strb_base = '0;
    for (int i = 0; i < SW; i++) begin
      strb_base[i] = (32'(i) < nbytes);
    end
  end

  assign full  = (count == CW'(MAX_OUTST));
  assign empty = (count == '0);
  assign busy  = ~empty;

  // A good op needs a free slot and memory acceptance; a bad op is swallowed
  // unless an earlier exception is still waiting for the report register.
  assign issue_rdy  = ~pend_vld & (bad | (req_rdy & ~full));
  assign req_vld    = issue_vld & ~pend_vld & ~bad & ~full;
  assign req_addr   = {ea[XLEN-1:OW], {OW{1'b0}}};
  assign req_st     = issue_st;
  assign req_data   = issue_wdata << {off, 3'b000};
  assign req_strobe = strb_base << off;

  assign push   = req_vld & req_rdy;
  assign bad_hs = issue_vld & issue_rdy & bad;

  assign head  = fifo_mem[rd_ptr];
  assign h_ea  = head[XLEN-1:0];
  assign h_off = head[XLEN +: OW];
  assign h_rd  = head[XLEN+OW +: GPR_AW];
  assign h_f3  = head[XLEN+OW+GPR_AW +: 3];
  assign h_st  = head[EW-1];

  assign rsp_rdy = 1'b1;
  assign pop     = rsp_vld & ~empty;
  assign fault   = pop & rsp_err;

  // Shift the addressed bytes down and sign/zero-extend by access size.
  always_comb begin
    sh       = rsp_data >> {h_off, 3'b000};
    ext_mask = ~({XLEN{1'b1}} << (32'd8 << h_f3[1:0]));
    top_bit  = ext_mask & ~(ext_mask >> 1);
    sgn      = |(sh & top_bit);
    wb_data  = (sh & ext_mask) | ((~h_f3[2] & sgn) ? ~ext_mask : '0);
  end

  assign wb_en   = pop & ~h_st & ~rsp_err & (h_rd != '0);
  assign wb_addr = h_rd;

  // FIFO payload storage; only the pointers and count need a reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {issue_st, issue_funct3, issue_rd, off, ea};
    end
  end

  // FIFO pointers and occupancy; full is taken from the registered count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(MAX_OUTST - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(MAX_OUTST - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Exception report register: response faults win, a displaced issue-side
  // exception waits one cycle in the pending register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      excp_vld   <= 1'b0;
      excp_cause <= 2'd0;
      excp_addr  <= '0;
      pend_vld   <= 1'b0;
      pend_cause <= 2'd0;
      pend_addr  <= '0;
    end else begin
      excp_vld <= 1'b0;
      if (fault) begin
        excp_vld   <= 1'b1;
        excp_cause <= 2'd2;
        excp_addr  <= h_ea;
        if (bad_hs) begin
          pend_vld   <= 1'b1;
          pend_cause <= bad_cause;
          pend_addr  <= ea;
        end
      end else if (pend_vld) begin
        excp_vld   <= 1'b1;
        excp_cause <= pend_cause;
        excp_addr  <= pend_addr;
        pend_vld   <= 1'b0;
      end else if (bad_hs) begin
        excp_vld   <= 1'b1;
        excp_cause <= bad_cause;
        excp_addr  <= ea;
      end
    end
  end

  // Sticky flag for a response that had no outstanding request to match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err <= 1'b0;
    end else if (rsp_vld & empty) begin
      proto_err <= 1'b1;
    end
  end

endmodule
